// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage types: branch funct3 codes, the skid entry payload and skid FSM states.
package rv_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned F3_W    = 3;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  // Flags are packed {N,Z,V,C}; regwrite is already cleared for branches.
  typedef struct packed {
    logic [DATA_W-1:0]  res;
    logic [FLAGS_W-1:0] flags;
    logic [RD_W-1:0]    rd;
    logic               regwrite;
    logic               taken;
  } ex_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/ex_result_skid_if.sv
// Execute-result handshake bundle: ALU capture side (in_*) and mem/wb side (out_*).
interface ex_result_skid_if;

  logic                       in_valid;
  logic                       in_ready;
  logic [rv_pkg::DATA_W-1:0]  in_res;
  logic                       in_n;
  logic                       in_z;
  logic                       in_v;
  logic                       in_c;
  logic [rv_pkg::RD_W-1:0]    in_rd;
  logic                       in_regwrite;
  logic                       in_branch;
  logic [rv_pkg::F3_W-1:0]    in_funct3;

  logic                       out_valid;
  logic                       out_ready;
  logic [rv_pkg::DATA_W-1:0]  out_res;
  logic [rv_pkg::FLAGS_W-1:0] out_flags;
  logic [rv_pkg::RD_W-1:0]    out_rd;
  logic                       out_regwrite;
  logic                       out_taken;

  modport master (
    output in_valid, in_res, in_n, in_z, in_v, in_c, in_rd, in_regwrite, in_branch, in_funct3,
    output out_ready,
    input  in_ready,
    input  out_valid, out_res, out_flags, out_rd, out_regwrite, out_taken
  );

  modport slave (
    input  in_valid, in_res, in_n, in_z, in_v, in_c, in_rd, in_regwrite, in_branch, in_funct3,
    input  out_ready,
    output in_ready,
    output out_valid, out_res, out_flags, out_rd, out_regwrite, out_taken
  );

endinterface

// File: rtl/ex_result_skid_branch_cond.sv
// Combinational RV32 B-type condition from ALU flags; shared with branch-prediction checks.
module branch_cond
  import rv_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic            n,
  input  logic            z,
  input  logic            v,
  input  logic            c,
  output logic            cond_c
);

  always_comb begin
    cond_c = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond_c = z;
      F3_BNE:  cond_c = ~z;
      F3_BLT:  cond_c = n ^ v;
      F3_BGE:  cond_c = ~(n ^ v);
      F3_BLTU: cond_c = ~c;
      F3_BGEU: cond_c = c;
      default: cond_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_result_skid.sv
// Registered ALU result stage with branch resolution and a 2-entry skid buffer toward mem/wb.
module ex_result_skid
  import rv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  ex_result_skid_if.slave  bus
);

  skid_state_t state_q;
  skid_state_t state_nx;
  ex_entry_t   head_q;
  ex_entry_t   head_nx;
  ex_entry_t   skid_q;
  ex_entry_t   skid_nx;
  ex_entry_t   in_entry;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        cond;
  logic        accept;
  logic        pop;

  branch_cond u_branch_cond (
    .funct3 (bus.in_funct3),
    .n      (bus.in_n),
    .z      (bus.in_z),
    .v      (bus.in_v),
    .c      (bus.in_c),
    .cond_c (cond)
  );

  // Branches never write rd; taken is resolved once, at capture.
  always_comb begin
    in_entry          = '0;
    in_entry.res      = bus.in_res;
    in_entry.flags    = {bus.in_n, bus.in_z, bus.in_v, bus.in_c};
    in_entry.rd       = bus.in_rd;
    in_entry.regwrite = bus.in_regwrite & ~bus.in_branch;
    in_entry.taken    = bus.in_branch & cond;
  end

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = out_valid_q & bus.out_ready;

  always_comb begin
    state_nx = state_q;
    head_nx  = head_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_nx = ONE;
            head_nx  = in_entry;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_nx = in_entry;
          end else if (accept) begin
            state_nx = FULL;
            skid_nx  = in_entry;
          end else if (pop) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_nx = ONE;
            head_nx  = skid_q;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so out_ready never reaches in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nx;
      head_q      <= head_nx;
      skid_q      <= skid_nx;
      in_ready_q  <= (state_nx != FULL);
      out_valid_q <= (state_nx != EMPTY);
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_res      = head_q.res;
  assign bus.out_flags    = head_q.flags;
  assign bus.out_rd       = head_q.rd;
  assign bus.out_regwrite = head_q.regwrite;
  assign bus.out_taken    = head_q.taken;

endmodule

// File: doc/ex_result_skid.md
# ex_result_skid

Registered output stage directly downstream of the RV32 ALU. Captures the ALU result and N/Z/V/C flags with the destination-register tag. Resolves the branch condition for B-type instructions from the flags. Presents everything to the memory/writeback stage through a 2-entry valid/ready skid buffer, so downstream stalls never combinationally reach the execute stage.

## Interface
- `DATA_W`, 32, result width
- `RD_W`, 5, destination register index width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `flush`  in  1  synchronous pipeline flush; drops all held entries
- `in_valid`  in  1  upstream entry valid
- `in_ready`  out  1  buffer can accept; driven from a register only
- `in_res`  in  DATA_W  ALU result
- `in_n`, `in_z`, `in_v`, `in_c`  in  1 each  ALU negative/zero/overflow/carry flags
- `in_rd`  in  RD_W  destination register
- `in_regwrite`  in  1  entry writes `rd`
- `in_branch`  in  1  entry is a conditional branch
- `in_funct3`  in  3  branch condition select
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  downstream accepts head
- `out_res`  out  DATA_W  head result
- `out_flags`  out  4  head flags packed {N,Z,V,C}
- `out_rd`  out  RD_W  head destination
- `out_regwrite`  out  1  head write enable; forced 0 when head is a branch
- `out_taken`  out  1  head branch taken; 0 for non-branch

## Operation
- Accept when `in_valid & in_ready`. Pop when `out_valid & out_ready`.
- Branch condition is evaluated at capture from the incoming flags; `taken = in_branch & cond`:
  - 000 BEQ: Z
  - 001 BNE: ~Z
  - 100 BLT: N^V
  - 101 BGE: ~(N^V)
  - 110 BLTU: ~C
  - 111 BGEU: C
  - 010, 011: 0 (not taken)
- Stored entry holds {res, flags, rd, regwrite & ~branch, taken}.
- FSM states:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - ONE: head register valid, `in_ready`=1.
  - FULL: head and skid valid, `in_ready`=0.
- Transitions:
  - EMPTY: accept → ONE (load head).
  - ONE: accept & pop → ONE (load head). Accept & ~pop → FULL (load skid). Pop & ~accept → EMPTY.
  - FULL: pop → ONE (skid moves to head). No accept possible.
- `in_ready` is the registered value of "next state ≠ FULL".
- `flush` has priority over accept and pop: next state EMPTY, `in_ready`=1. An entry offered in the flush cycle is dropped.
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1. All data outputs are 0: `out_res`=0, `out_flags`=0, `out_rd`=0, `out_regwrite`=0, `out_taken`=0.
- When `out_valid`=0, data outputs hold their last value. Downstream must qualify them with `out_valid`.
- Reset asserted mid-transfer discards both entries immediately (asynchronous).

## Timing
- Latency: accept in cycle t → `out_valid` with that entry in cycle t+1.
- Throughput: 1 entry/cycle while `out_ready`=1.
- No combinational path from `out_ready` to `in_ready`, or from any input to any output.
- Outputs stay stable while `out_valid & ~out_ready`.
- Order is strictly FIFO; there is no drop or duplication except on `flush`/reset.

## Structure
- Shared package `rv_pkg` holds:
  - funct3 branch constants: `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`, `F3_BLTU`, `F3_BGEU`
  - a packed `ex_entry_t` struct {res, flags, rd, regwrite, taken}
  - the state enum {EMPTY, ONE, FULL}
- One natural sub-module: `branch_cond`, combinational, (funct3, N, Z, V, C) → cond. It is reused by any future branch-prediction check.
- Top holds two `ex_entry_t` registers plus the FSM.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → `out_valid`=0, `in_ready`=1, all data outputs 0. Release → first entry appears one cycle after accept.
- Streaming: 8 back-to-back entries with res=1..8, `out_ready`=1 → outputs 1..8 on consecutive cycles, `in_ready` never drops.
- Backpressure:
  - Enqueue res=0xA, 0xB with `out_ready`=0 → state FULL, `in_ready`=0, head holds 0xA.
  - Raise `out_ready` → 0xA, then 0xB, then `out_valid`=0.
- Branch decode, one case per funct3:
  - Z=1, BEQ → taken=1, regwrite=0.
  - N=1, V=1, BLT → taken=0.
  - C=0, BLTU → taken=1.
  - funct3=010 → taken=0.
  - `in_branch`=0 with Z=1 → taken=0.
- Flush in FULL while offering a new entry → next cycle `out_valid`=0, `in_ready`=1, new entry never appears.
- Async reset pulse mid-stream (between clock edges) → `out_valid` drops immediately, no stale entry after release.
